state_machine_extended: RTL and testbench
=========================================

# state_machine_extended

Microsequencer next-state controller for the ARMv4 core with the vector extension. It tracks the current control-store address (7 bits) and produces the next address each cycle. Its inputs are the fetch handshake, the condition-pass flag, the decoded instruction family and the vector opcode fields. It sits between the decode logic and the control store. The datapath sees its state through `address` and a few loop-control strobes.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset; forces `address` to 104.
- `COND`  in  1  instruction condition passed (1 = execute).
- `ST`  in  1  IR[20], load/store direction; carried for scalar families, unused by vector flow.
- `PL`  in  1  IR[24], pre/post-index; carried for scalar families, unused by vector flow.
- `A`  in  1  IR[21], writeback; carried for scalar families, unused by vector flow.
- `MEM_R`  in  1  memory ready for the instruction fetch.
- `family_number`  in  4  decoded instruction family.
- `OP`  in  2  IR[24:23], vector opcode.
- `Z`  in  1  IR[22], zero destination before dot product.
- `RM_CNTR_DONE`  in  1  external element counter has reached its last element.
- `is_VEC`  in  1  instruction belongs to the vector extension.
- `address`  out  7  current microstate.
- `DOT_PROD_RST`  out  1  clear the dot-product accumulator/Rd; high only in state 121.
- `RM_CNTR_INIT`  out  1  initialise the element counter; high in states 114, 116, 118.
- `RM_CNTR_INC`  out  1  advance the element counter; high in states 115, 117, 119.

## Operation
- All outputs are Moore functions of `address` only.
- **Fetch, 104:** goes to 105 unconditionally.
- **Fetch wait, 105:** stays in 105 while `MEM_R`=0. Goes to 106 when `MEM_R`=1.
- **Decode, 106:**
  - `COND`=0 → 104 (instruction skipped).
  - `is_VEC`=1 → dispatch on `OP`:
    - 01 (dot product) → 114.
    - 10 (vector×scalar) → 116.
    - 11 (vector add) → 118.
    - 00 (reserved) → 104.
  - `is_VEC`=0 → state `{3'b000, family_number}` (0..15).
- **Scalar entry states 0..15:** one execute cycle, then → 104.
- **Dot product:**
  - 114 → 121 if `Z`=1, else → 113.
  - 121 → 113.
  - 113 (shared element-load state) → 115 when `OP`=01.
  - 115 → 104 if `RM_CNTR_DONE`, else → 113.
- **Vector×scalar:**
  - 116 → 113.
  - 113 → 117 when `OP`≠01.
  - 117 → 104 if `RM_CNTR_DONE`, else → 113.
- **Vector add:**
  - 118 → 119.
  - 119 self-loops while `RM_CNTR_DONE`=0, then → 104.
- **Loop exit sampling:** `RM_CNTR_DONE` is sampled only in 115, 117 and 119. Its value in 113 is ignored.
- **Illegal states:** any unlisted address (16..103, 107..112, 120, 122..127) → 104.

## Timing
- **Reset:** while `rst`=0, `address`=104, `DOT_PROD_RST`=0, `RM_CNTR_INIT`=0, `RM_CNTR_INC`=0. Reset takes effect asynchronously, including mid-loop.
- **Decode latency:** fetch→decode is a minimum of 3 cycles (104, 105, 106).
- **Dot product / vector×scalar cycle count:**
  - The loop costs 2 cycles per element (113, 115/117).
  - Total from 106 is 1 + 2N cycles, plus 1 more for dot product with `Z`=1.
- **Vector add:** 1 + N cycles from 106.
- **Loop termination:** the last loop state sees `RM_CNTR_DONE`=1, and the next edge returns to 104.
- **Input timing:** `IR`-derived inputs must be stable by the rising edge that leaves 106, and must remain stable through the whole vector loop.

## Test plan
- **Fetch/reset:**
  - Pulse `rst`=0 mid-loop (in 115) → `address`=104 immediately.
  - Release with `MEM_R`=1 → 105, then 106.
  - With `MEM_R`=0 held, the FSM holds in 105.
- **Dot product with zero, IR=0x06C00010** (`OP`=01, `Z`=1, `family_number`=15, `is_VEC`=1, `COND`=1):
  - Sequence 104,105,106,114,121, then 113,115 repeated 5 times, then 104.
  - `RM_CNTR_DONE` asserted during the 5th visit to 115.
  - `DOT_PROD_RST`=1 only in 121.
- **Dot product without zero, IR=0x06800010:** sequence 104,105,106,114, then (113,115)×5, then 104.
- **Vector×scalar, IR=0x07000010:** sequence 104,105,106,116, then (113,117)×5, then 104.
- **Vector add, IR=0x07800010:**
  - Sequence 104,105,106,118, then 119×5 with `RM_CNTR_DONE` on the 5th visit, then 104.
  - `RM_CNTR_INC`=1 in each 119.
- **Condition fail / reserved / scalar:**
  - `COND`=0 at 106 → 104.
  - `OP`=00 with `is_VEC`=1 → 104.
  - `is_VEC`=0, `family_number`=3 → 3, then 104.

Source files
------------

// File: rtl/state_machine_extended.sv
// Microsequencer next-state controller for the ARMv4 core with the vector
// extension. Holds the current control-store address and steps it once per
// clock from the fetch handshake, condition flag and decoded opcode fields.
//
// state | meaning
// 0-15  | scalar family execute (one cycle)
// 104   | fetch
// 105   | fetch wait for memory ready
// 106   | decode / dispatch
// 113   | vector element load (shared by dot product and vector x scalar)
// 114   | dot product entry, counter init
// 115   | dot product element step, counter increment
// 116   | vector x scalar entry, counter init
// 117   | vector x scalar element step, counter increment
// 118   | vector add entry, counter init
// 119   | vector add element step, counter increment
// 121   | dot product destination clear
// other | illegal, recovers to fetch

module state_machine_extended (
  input  logic       clk,
  input  logic       rst,
  input  logic       COND,
  input  logic       ST,
  input  logic       PL,
  input  logic       A,
  input  logic       MEM_R,
  input  logic [3:0] family_number,
  input  logic [1:0] OP,
  input  logic       Z,
  input  logic       RM_CNTR_DONE,
  input  logic       is_VEC,
  output logic [6:0] address,
  output logic       DOT_PROD_RST,
  output logic       RM_CNTR_INIT,
  output logic       RM_CNTR_INC
);

  localparam logic [6:0] S_FETCH    = 7'd104;
  localparam logic [6:0] S_WAIT     = 7'd105;
  localparam logic [6:0] S_DECODE   = 7'd106;
  localparam logic [6:0] S_ELEM_LD  = 7'd113;
  localparam logic [6:0] S_DOT_INIT = 7'd114;
  localparam logic [6:0] S_DOT_STEP = 7'd115;
  localparam logic [6:0] S_VXS_INIT = 7'd116;
  localparam logic [6:0] S_VXS_STEP = 7'd117;
  localparam logic [6:0] S_ADD_INIT = 7'd118;
  localparam logic [6:0] S_ADD_STEP = 7'd119;
  localparam logic [6:0] S_DOT_ZERO = 7'd121;

  localparam logic [1:0] OP_RSVD = 2'b00;
  localparam logic [1:0] OP_DOT  = 2'b01;
  localparam logic [1:0] OP_VXS  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  logic [6:0] next_address;

  // Scalar addressing-mode bits travel with the instruction but do not steer
  // this sequencer; folded here so they are visibly consumed.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ST, PL, A};

  // State register; reset returns to fetch immediately, even mid-loop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address <= S_FETCH;
    end else begin
      address <= next_address;
    end
  end

  // Next-state selection; anything not listed falls back to fetch.
  always_comb begin
    next_address = S_FETCH;
    case (address)
      S_FETCH: next_address = S_WAIT;
      S_WAIT:  next_address = MEM_R ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (!COND) begin
          next_address = S_FETCH;
        end else if (is_VEC) begin
          case (OP)
            OP_DOT:  next_address = S_DOT_INIT;
            OP_VXS:  next_address = S_VXS_INIT;
            OP_ADD:  next_address = S_ADD_INIT;
            OP_RSVD: next_address = S_FETCH;
            default: next_address = S_FETCH;
          endcase
        end else begin
          next_address = {3'b000, family_number};
        end
      end
      S_DOT_INIT: next_address = Z ? S_DOT_ZERO : S_ELEM_LD;
      S_DOT_ZERO: next_address = S_ELEM_LD;
      // The element-load state is shared, so the opcode picks the way back.
      S_ELEM_LD:  next_address = (OP == OP_DOT) ? S_DOT_STEP : S_VXS_STEP;
      S_DOT_STEP: next_address = RM_CNTR_DONE ? S_FETCH : S_ELEM_LD;
      S_VXS_INIT: next_address = S_ELEM_LD;
      S_VXS_STEP: next_address = RM_CNTR_DONE ? S_FETCH : S_ELEM_LD;
      S_ADD_INIT: next_address = S_ADD_STEP;
      S_ADD_STEP: next_address = RM_CNTR_DONE ? S_FETCH : S_ADD_STEP;
      // Scalar execute states 0..15 and illegal states both return to fetch.
      default:    next_address = S_FETCH;
    endcase
  end

  // Moore strobes decoded from the current address only.
  always_comb begin
    DOT_PROD_RST = 1'b0;
    RM_CNTR_INIT = 1'b0;
    RM_CNTR_INC  = 1'b0;
    case (address)
      S_DOT_ZERO: DOT_PROD_RST = 1'b1;
      S_DOT_INIT, S_VXS_INIT, S_ADD_INIT: RM_CNTR_INIT = 1'b1;
      S_DOT_STEP, S_VXS_STEP, S_ADD_STEP: RM_CNTR_INC = 1'b1;
      default: begin
        DOT_PROD_RST = 1'b0;
        RM_CNTR_INIT = 1'b0;
        RM_CNTR_INC  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_state_machine_extended.sv
// Scoreboard bench for state_machine_extended: a planner expands each
// instruction into its expected microstate trace, the driver replays it and
// queues expectations, and a negedge monitor compares the DUT against them.

module tb_state_machine_extended;

  logic       clk;
  logic       rst;
  logic       COND, ST, PL, A, MEM_R, Z, RM_CNTR_DONE, is_VEC;
  logic [3:0] family_number;
  logic [1:0] OP;
  logic [6:0] address;
  logic       DOT_PROD_RST, RM_CNTR_INIT, RM_CNTR_INC;

  state_machine_extended dut (
    .clk(clk), .rst(rst), .COND(COND), .ST(ST), .PL(PL), .A(A),
    .MEM_R(MEM_R), .family_number(family_number), .OP(OP), .Z(Z),
    .RM_CNTR_DONE(RM_CNTR_DONE), .is_VEC(is_VEC), .address(address),
    .DOT_PROD_RST(DOT_PROD_RST), .RM_CNTR_INIT(RM_CNTR_INIT),
    .RM_CNTR_INC(RM_CNTR_INC)
  );

  typedef struct {
    int   addr;
    logic mem_r;
    logic done;
  } step_t;

  step_t plan_q[$];
  int    exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobes as a function of the microstate number.
  function automatic logic [2:0] strobes_for(input int a);
    logic [2:0] s;
    s[2] = (a == 121);
    s[1] = (a == 114) || (a == 116) || (a == 118);
    s[0] = (a == 115) || (a == 117) || (a == 119);
    return s;
  endfunction

  // Monitor: one scoreboard entry per cycle, sampled away from the edge.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      int e;
      e = exp_q.pop_front();
      checks++;
      if (address !== 7'(e) ||
          {DOT_PROD_RST, RM_CNTR_INIT, RM_CNTR_INC} !== strobes_for(e)) begin
        failures++;
        $display("FAIL trace @%0t: got addr=%0d strobes=%b, want addr=%0d strobes=%b",
                 $time, address, {DOT_PROD_RST, RM_CNTR_INIT, RM_CNTR_INC},
                 e, strobes_for(e));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input int a, input logic m, input logic d);
    step_t s;
    s.addr = a; s.mem_r = m; s.done = d;
    plan_q.push_back(s);
  endtask

  // Expand one instruction into its microstate trace, starting at fetch and
  // stopping before the fetch that begins the next instruction. The counter
  // done flag is random except on the step that must end the loop.
  task automatic build_plan(input logic cond, input logic vec, input logic [1:0] op,
                            input logic z, input logic [3:0] fam, input int n,
                            input int w);
    plan_q.delete();
    add(104, rbit(), rbit());
    for (int i = 0; i < w; i++) add(105, 1'b0, rbit());
    add(105, 1'b1, rbit());
    add(106, rbit(), rbit());
    if (!cond) return;
    if (!vec) begin
      add(int'(fam), rbit(), rbit());
      return;
    end
    case (op)
      2'b01: begin
        add(114, rbit(), rbit());
        if (z) add(121, rbit(), rbit());
        for (int e = 1; e <= n; e++) begin
          add(113, rbit(), rbit());
          add(115, rbit(), e == n);
        end
      end
      2'b10: begin
        add(116, rbit(), rbit());
        for (int e = 1; e <= n; e++) begin
          add(113, rbit(), rbit());
          add(117, rbit(), e == n);
        end
      end
      2'b11: begin
        add(118, rbit(), rbit());
        for (int e = 1; e <= n; e++) add(119, rbit(), e == n);
      end
      default: ;
    endcase
  endtask

  task automatic set_fields(input logic [31:0] ir, input logic cond, input logic vec,
                            input logic [3:0] fam);
    OP = ir[24:23]; Z = ir[22]; A = ir[21]; ST = ir[20]; PL = ir[24];
    COND = cond; is_VEC = vec; family_number = fam;
  endtask

  // Replay the plan; called at posedge+1. stop_at >= 0 leaves the driver
  // parked inside that step instead of advancing past it.
  task automatic run_plan(input int stop_at);
    for (int i = 0; i < plan_q.size(); i++) begin
      MEM_R = plan_q[i].mem_r;
      RM_CNTR_DONE = plan_q[i].done;
      exp_q.push_back(plan_q[i].addr);
      if (i == stop_at) return;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic cond, input logic vec,
                           input logic [3:0] fam, input int n, input int w);
    set_fields(ir, cond, vec, fam);
    build_plan(cond, vec, ir[24:23], ir[22], fam, n, w);
    run_plan(-1);
  endtask

  task automatic direct_check(input string name, input logic [9:0] got,
                              input logic [9:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got addr/strobes=%0d/%b, want %0d/%b",
               name, got[9:3], got[2:0], want[9:3], want[2:0]);
    end
  endtask

  initial begin
    int idx, seen;
    rst = 1'b0;
    MEM_R = 1'b0; RM_CNTR_DONE = 1'b0;
    set_fields(32'h0, 1'b0, 1'b0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    direct_check("reset_state", {address, DOT_PROD_RST, RM_CNTR_INIT, RM_CNTR_INC},
                 {7'd104, 3'b000});
    rst = 1'b1;
    mon_en = 1'b1;

    // Directed cases from the plan, each with five elements.
    run_instr(32'h06C00010, 1'b1, 1'b1, 4'd15, 5, 0);
    run_instr(32'h06800010, 1'b1, 1'b1, 4'd15, 5, 0);
    run_instr(32'h07000010, 1'b1, 1'b1, 4'd15, 5, 0);
    run_instr(32'h07800010, 1'b1, 1'b1, 4'd15, 5, 0);
    run_instr(32'h06C00010, 1'b0, 1'b1, 4'd15, 5, 0);
    run_instr(32'h00000010, 1'b1, 1'b1, 4'd15, 5, 0);
    run_instr(32'h00000003, 1'b1, 1'b0, 4'd3, 5, 3);
    run_instr(32'h07800010, 1'b1, 1'b1, 4'd0, 1, 2);

    // Asynchronous reset in the middle of a dot-product loop (second 115).
    set_fields(32'h06800010, 1'b1, 1'b1, 4'd15);
    build_plan(1'b1, 1'b1, 2'b01, 1'b0, 4'd15, 5, 0);
    idx = -1; seen = 0;
    for (int i = 0; i < plan_q.size(); i++) begin
      if (plan_q[i].addr == 115) begin
        seen++;
        if (seen == 2 && idx < 0) idx = i;
      end
    end
    run_plan(idx);
    @(negedge clk); #1;
    mon_en = 1'b0;
    direct_check("pre_reset_in_115", {address, DOT_PROD_RST, RM_CNTR_INIT, RM_CNTR_INC},
                 {7'd115, 3'b001});
    rst = 1'b0;
    #1;
    direct_check("async_reset_mid_loop",
                 {address, DOT_PROD_RST, RM_CNTR_INIT, RM_CNTR_INC}, {7'd104, 3'b000});
    @(posedge clk); #1;
    direct_check("reset_held", {address, DOT_PROD_RST, RM_CNTR_INIT, RM_CNTR_INC},
                 {7'd104, 3'b000});
    MEM_R = 1'b1;
    rst = 1'b1;
    mon_en = 1'b1;
    run_instr(32'h07000010, 1'b1, 1'b1, 4'd0, 2, 0);

    // Randomised instructions.
    for (int t = 0; t < 80; t++) begin
      logic [31:0] ir;
      ir = $urandom;
      run_instr(ir, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(0, 3));
    end

    // Last instruction must have returned to fetch.
    MEM_R = rbit(); RM_CNTR_DONE = rbit();
    exp_q.push_back(104);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
